mc_seq_ctrl: RTL

Multi-cycle sequencing controller for the RV32I core datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and handshakes with the instruction and data memory ports. It emits the write strobes for the PC, instruction register, memory data register and register file, and halts on ebreak, illegal opcode or a memory timeout. It sits beside the decoder, consumes its classification flags, and provides cycle and retired-instruction counters.

---
 rtl/mc_seq_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencing controller for the RV32I datapath.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, handshakes
// with the instruction/data memory ports, drives the datapath write strobes,
// halts on ebreak, illegal opcode or memory timeout, and counts cycles and
// retired instructions.
module mc_seq_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_reg_wr,
    input  logic             dec_is_ebreak,
    input  logic             dec_illegal,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] E_NONE    = 2'b00;
    localparam logic [1:0] E_FETCHTO = 2'b01;
    localparam logic [1:0] E_ILLEGAL = 2'b10;
    localparam logic [1:0] E_DATATO  = 2'b11;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_nx;
    logic [1:0]      err_nx;
    logic            retire;
    logic            ld_f;
    logic            st_f;
    logic            rw_f;

    assign state_dbg = state;

    // Next-state, wait counter, error code and strobe decode; strobes are masked during reset
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        err_nx   = err_code;
        retire   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    // ack beats a coincident timeout
                    ir_we    = 1'b1;
                    wait_nx  = '0;
                    state_nx = S_DECODE;
                end else if (wait_cnt == TO_LIM) begin
                    state_nx = S_HALT;
                    err_nx   = E_FETCHTO;
                end else begin
                    wait_nx = wait_cnt + TO_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_nx = S_HALT;
                    err_nx   = E_ILLEGAL;
                end else if (dec_is_ebreak) begin
                    // ebreak retires but never commits a new PC
                    state_nx = S_HALT;
                    err_nx   = E_NONE;
                    retire   = 1'b1;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nx = (ld_f || st_f) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = st_f;
                if (dmem_ack) begin
                    wait_nx = '0;
                    if (st_f) begin
                        // stores have nothing to write back, so they commit here
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        mdr_we   = 1'b1;
                        state_nx = S_WB;
                    end
                end else if (wait_cnt == TO_LIM) begin
                    state_nx = S_HALT;
                    err_nx   = E_DATATO;
                end else begin
                    wait_nx = wait_cnt + TO_W'(1);
                end
            end
            S_WB: begin
                reg_we   = rw_f;
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                // unused encodings are treated as a corrupted sequencer
                state_nx = S_HALT;
                err_nx   = E_ILLEGAL;
            end
        endcase
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            ir_we    = 1'b0;
            mdr_we   = 1'b0;
            reg_we   = 1'b0;
            pc_we    = 1'b0;
        end
    end

    // State, counters, sticky halt/error and decoder flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            halted      <= 1'b0;
            err_code    <= E_NONE;
            ld_f        <= 1'b0;
            st_f        <= 1'b0;
            rw_f        <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            err_code <= err_nx;
            if (state_nx == S_HALT) begin
                halted <= 1'b1;
            end
            // the cycle that enters HALT still counts
            if (state != S_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
            // decoder outputs are only trusted during DECODE
            if (state == S_DECODE) begin
                ld_f <= dec_is_load;
                st_f <= dec_is_store;
                rw_f <= dec_reg_wr;
            end
        end
    end

endmodule
